atb_trace_packer: RTL
=====================

Name: atb_trace_packer

Overview:
- ATB transmitter stage sitting directly upstream of the ATB trace interface.
- Accepts a byte-wide trace stream from a trace source and packs it little-endian into 32-bit ATB transfers.
- Buffers transfers in a word FIFO and drives the ATB master signals (atvalid/atdata/atbytes/atid).
- Services flush (afvalid/afready), forwards synchronisation requests to the source, and drives atwakeup.

Parameters:
- FIFO_DEPTH, 4, number of buffered ATB transfers; power of two, at least 2.
- IDLE_TIMEOUT, 16, atclken-qualified cycles without a new byte before a partial word is emitted; 0 disables the timeout.

Ports:
- atclk  in  1  trace clock
- atreset  in  1  reset, synchronous, active-high
- atclken  in  1  clock enable; all state advances only on edges where atclken=1
- src_data  in  8  trace byte from source
- src_valid  in  1  src_data valid
- src_ready  out  1  packer accepts byte this cycle
- src_sync  out  1  one-cycle pulse asking the source to emit a sync packet
- cfg_atid  in  7  trace source ID; static during operation
- atdata  out  32  ATB trace data
- atbytes  out  2  valid bytes minus 1
- atid  out  7  source ID of current transfer
- atvalid  out  1  transfer valid
- atready  in  1  receiver ready
- afvalid  in  1  flush request
- afready  out  1  flush complete
- syncreq  in  1  synchronisation request from receiver
- atwakeup  out  1  transmitter holds or is producing data

Behaviour:
- Interface: one clock (atclk); reset is synchronous and active-high (atreset).
- Reset values: src_ready=0, src_sync=0, atvalid=0, atdata=0, atbytes=0, atid=0, afready=0, atwakeup=0. Accumulator and FIFO empty, timeout counter 0, state IDLE. Reset mid-transfer discards all buffered data; atvalid drops on the following cycle.
- Enable: "Enabled edge" means atclk rising edge with atclken=1.
- Byte acceptance: a byte is accepted on an enabled edge when src_valid & src_ready. It is written into lane acc_cnt (bits 8*acc_cnt+7:8*acc_cnt), and acc_cnt increments.
- Word push: on the 4th byte, push {acc data, atbytes=3, cfg_atid} into the FIFO on that same edge, and reset acc_cnt to 0.
- src_ready = (state==IDLE) & ~(acc_cnt==3 & fifo_full). A push and a pop on the same edge are allowed; full-check uses pre-edge occupancy.
- ATB output: the FIFO is show-ahead. atvalid = ~fifo_empty, and atdata/atbytes/atid = FIFO head.
- Latency: a word pushed at edge T is presented with atvalid=1 after edge T.
- Pop: on an enabled edge with atvalid & atready. Head fields are stable while atvalid=1 and atready=0.
- Partial word: atdata bytes above atbytes are driven 0.
- Idle timeout:
  - The counter clears on every accepted byte or when acc_cnt==0, and increments otherwise.
  - At IDLE_TIMEOUT with acc_cnt>0, push a partial word with atbytes=acc_cnt-1 and clear acc_cnt.
  - If the FIFO is full, the push waits, and the counter saturates.
- Flush FSM, IDLE -> FLUSH -> ACK -> IDLE:
  - IDLE->FLUSH on an enabled edge with afvalid=1. A byte accepted on that same edge is kept.
  - In FLUSH: src_ready=0. If acc_cnt>0 and the FIFO is not full, push the partial word. When acc_cnt==0 and the FIFO is empty (last transfer handshaken), go to ACK.
  - In ACK: afready=1 for exactly one enabled cycle, then return to IDLE. afvalid is expected low after that cycle.
  - afvalid arriving with everything already empty: FLUSH->ACK in one edge, so afready rises 2 edges after the request.
- syncreq: a rising edge of syncreq (registered previous value) produces src_sync=1 for one enabled cycle. A syncreq held high produces one pulse only.
- atwakeup = atvalid | (acc_cnt!=0) | (state!=IDLE).
- When atclken=0: outputs hold, and no handshakes complete.

Decomposition:
- Package atb_pkg:
  - ATB_DATA_W=32, ATB_BYTES_W=2, ATB_ID_W=7.
  - typedef atb_xfer_t struct {data, bytes, id}.
  - enum flush_state_t {IDLE, FLUSH, ACK}.
- One sub-module, atb_sync_fifo (parameterised width/depth):
  - show-ahead, ce input, full/empty flags.
  - Instantiated once for atb_xfer_t.

Test Plan:
- Pack: bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles, atready=1, cfg_atid=0x10 -> one transfer atdata=0x44332211, atbytes=3, atid=0x10, atvalid high exactly 1 cycle after the 4th byte.
- Backpressure: atready=0, push FIFO_DEPTH words plus 3 bytes -> src_ready=0 when the 4th byte would complete a word. Head data stays stable while stalled. Raising atready drains words in order with no loss or duplication.
- Flush with partial: bytes 0xAA,0xBB then afvalid=1, atready=1 -> transfer atdata=0x0000BBAA, atbytes=1. afready pulses one cycle after the last handshake, and src_ready=0 throughout.
- Idle timeout: IDLE_TIMEOUT=16, send 0x5A then stop -> transfer atdata=0x0000005A, atbytes=0, atvalid rising 17 edges after byte acceptance.
- atclken gating and sync: toggle atclken 1/0 during packing -> results identical to the ungated run, with the time scaled. syncreq held high for 5 cycles -> exactly one src_sync pulse.
- Reset mid-operation: assert atreset with 2 words buffered -> next cycle atvalid=0, afready=0, atwakeup=0, and no stale data afterwards.

Source files
------------

// File: rtl/atb_pkg.sv
// Shared ATB widths, transfer record and flush FSM encoding for the trace packer.
package atb_pkg;

  localparam int unsigned ATB_DATA_W  = 32;
  localparam int unsigned ATB_BYTES_W = 2;
  localparam int unsigned ATB_ID_W    = 7;

  typedef struct packed {
    logic [ATB_DATA_W-1:0]  data;
    logic [ATB_BYTES_W-1:0] bytes;
    logic [ATB_ID_W-1:0]    id;
  } atb_xfer_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    ACK
  } flush_state_t;

endpackage

// File: rtl/atb_sync_fifo.sv
// Show-ahead synchronous FIFO with clock enable; the head entry is visible on rdata while not empty.
module atb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full/empty are pre-edge flags, so a push into a full FIFO is refused even if a pop coincides.
  assign do_push = ce & push & ~full;
  assign do_pop  = ce & pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/atb_trace_packer.sv
// Packs a byte trace stream little-endian into 32-bit ATB transfers, with flush, idle timeout and sync forwarding.
module atb_trace_packer
  import atb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                   atclk,
  input  logic                   atreset,
  input  logic                   atclken,
  input  logic [7:0]             src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   src_sync,
  input  logic [ATB_ID_W-1:0]    cfg_atid,
  output logic [ATB_DATA_W-1:0]  atdata,
  output logic [ATB_BYTES_W-1:0] atbytes,
  output logic [ATB_ID_W-1:0]    atid,
  output logic                   atvalid,
  input  logic                   atready,
  input  logic                   afvalid,
  output logic                   afready,
  input  logic                   syncreq,
  output logic                   atwakeup
);

  localparam int unsigned TO_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(IDLE_TIMEOUT);
  localparam int unsigned XFER_W = $bits(atb_xfer_t);

  flush_state_t state;
  flush_state_t state_next;

  logic [1:0]            acc_cnt;
  logic [ATB_DATA_W-1:0] acc_data;
  logic [TO_W-1:0]       to_cnt;
  logic                  timeout_hit;
  logic                  sync_prev;

  logic                  byte_accept;
  logic                  full_push;
  logic                  part_push;
  logic                  push;
  logic                  pop;
  atb_xfer_t             push_xfer;
  atb_xfer_t             head;
  logic [XFER_W-1:0]     fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign src_ready   = ~atreset & (state == IDLE) & ~((acc_cnt == 2'd3) & fifo_full);
  assign byte_accept = atclken & src_valid & src_ready;
  assign full_push   = byte_accept & (acc_cnt == 2'd3);
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (to_cnt == TO_MAX);

  // Partial words leave via flush or timeout; both wait for FIFO space and never race a byte push.
  assign part_push = atclken & (acc_cnt != 2'd0) & ~fifo_full & ~byte_accept &
                     ((state == FLUSH) | ((state == IDLE) & timeout_hit));
  assign push      = full_push | part_push;
  assign pop       = atclken & atvalid & atready;

  always_comb begin
    push_xfer.data  = acc_data;
    push_xfer.bytes = acc_cnt - 2'd1;
    push_xfer.id    = cfg_atid;
    if (full_push) begin
      push_xfer.data[31:24] = src_data;
      push_xfer.bytes       = 2'd3;
    end
  end

  always_ff @(posedge atclk) begin
    if (atreset) begin
      acc_cnt  <= '0;
      acc_data <= '0;
    end else if (atclken) begin
      if (byte_accept) begin
        if (acc_cnt == 2'd3) begin
          acc_cnt  <= '0;
          acc_data <= '0;
        end else begin
          acc_data[{acc_cnt, 3'b000} +: 8] <= src_data;
          acc_cnt                          <= acc_cnt + 2'd1;
        end
      end else if (part_push) begin
        acc_cnt  <= '0;
        acc_data <= '0;
      end
    end
  end

  always_ff @(posedge atclk) begin
    if (atreset) begin
      to_cnt <= '0;
    end else if (atclken) begin
      if (byte_accept | (acc_cnt == 2'd0) | part_push) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge atclk) begin
    if (atreset) begin
      state <= IDLE;
    end else if (atclken) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (afvalid) state_next = FLUSH;
      FLUSH:   if ((acc_cnt == 2'd0) & fifo_empty) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge atclk) begin
    if (atreset) begin
      sync_prev <= 1'b0;
      src_sync  <= 1'b0;
    end else if (atclken) begin
      sync_prev <= syncreq;
      src_sync  <= syncreq & ~sync_prev;
    end
  end

  atb_sync_fifo #(
    .WIDTH(XFER_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (atclk),
    .rst   (atreset),
    .ce    (atclken),
    .push  (push),
    .wdata (push_xfer),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head     = atb_xfer_t'(fifo_rdata);
  assign atvalid  = ~fifo_empty;
  assign atdata   = atvalid ? head.data  : '0;
  assign atbytes  = atvalid ? head.bytes : '0;
  assign atid     = atvalid ? head.id    : '0;
  assign afready  = (state == ACK);
  assign atwakeup = atvalid | (acc_cnt != 2'd0) | (state != IDLE);

endmodule
